// File: rtl/game_countdown_timer.sv
// BCD seconds countdown driven by an external millisecond tick (IDLE/RUN/PAUSED/EXPIRED).
// Optional low-time warning output: define TIMER_WARN_EN.
module game_countdown_timer #(
   parameter int MS_PER_SEC = 1000,
   parameter int WARN_SECS  = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ms_tick,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   input  logic       start,
   input  logic       pause,
   output logic       tick_en,
   output logic [3:0] secs_tens,
   output logic [3:0] secs_ones,
   output logic       running,
`ifdef TIMER_WARN_EN
   output logic       warn,
`endif
   output logic       timeout
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSED  = 2'd2,
      ST_EXPIRED = 2'd3
   } state_t;

   localparam logic [9:0] MS_LAST = 10'(MS_PER_SEC - 1);

   generate
      if (MS_PER_SEC < 2 || MS_PER_SEC > 1023 || WARN_SECS < 0 || WARN_SECS > 99) begin : g_param_check
         $error("game_countdown_timer: parameter out of range");
      end
   endgenerate

   state_t     r_state;
   logic [9:0] r_ms;
   logic [3:0] r_tens;
   logic [3:0] r_ones;
   logic       r_tick_en;
   logic       r_timeout;

   state_t     w_state_nxt;
   logic [9:0] w_ms_nxt;
   logic [3:0] w_tens_nxt;
   logic [3:0] w_ones_nxt;
   logic       w_timeout_nxt;

   function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

   // next-state, digit and millisecond-counter logic
   always_comb begin
      w_state_nxt = r_state;
      w_ms_nxt    = r_ms;
      w_tens_nxt  = r_tens;
      w_ones_nxt  = r_ones;
      if (load) begin
         w_state_nxt = ST_IDLE;
         w_ms_nxt    = 10'd0;
         w_tens_nxt  = clamp_bcd(load_tens);
         w_ones_nxt  = clamp_bcd(load_ones);
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start && !pause) begin
                  w_state_nxt = (r_tens == 4'd0 && r_ones == 4'd0) ? ST_EXPIRED : ST_RUN;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (pause) begin
                  w_state_nxt = ST_PAUSED;
               end else if (ms_tick) begin
                  if (r_ms == MS_LAST) begin
                     // one full second elapsed: BCD borrow, never via binary
                     w_ms_nxt = 10'd0;
                     if (r_ones != 4'd0) begin
                        w_ones_nxt = r_ones - 4'd1;
                     end else begin
                        w_ones_nxt = 4'd9;
                        w_tens_nxt = r_tens - 4'd1;
                     end
                     if (r_tens == 4'd0 && r_ones == 4'd1) begin
                        w_state_nxt = ST_EXPIRED;
                     end else begin
                        w_state_nxt = ST_RUN;
                     end
                  end else begin
                     w_ms_nxt = r_ms + 10'd1;
                  end
               end else begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_PAUSED: begin
               if (start && !pause) begin
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_PAUSED;
               end
            end
            ST_EXPIRED: w_state_nxt = ST_EXPIRED;
            default:    w_state_nxt = ST_IDLE;
         endcase
      end
      w_timeout_nxt = (w_state_nxt == ST_EXPIRED) && (r_state != ST_EXPIRED);
   end

   // state, counters and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_ms      <= 10'd0;
         r_tens    <= 4'd0;
         r_ones    <= 4'd0;
         r_tick_en <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ms      <= w_ms_nxt;
         r_tens    <= w_tens_nxt;
         r_ones    <= w_ones_nxt;
         r_tick_en <= (w_state_nxt == ST_RUN);
         r_timeout <= w_timeout_nxt;
      end
   end

   assign tick_en   = r_tick_en;
   assign running   = r_tick_en;
   assign timeout   = r_timeout;
   assign secs_tens = r_tens;
   assign secs_ones = r_ones;

`ifdef TIMER_WARN_EN
   localparam logic [6:0] WARN_LIM = 7'(WARN_SECS);

   logic       r_warn;
   logic [6:0] w_secs_nxt;
   logic       w_warn_nxt;

   // warning tracks the next-cycle state so it lines up with the digits
   always_comb begin
      w_secs_nxt = 7'(w_tens_nxt) * 7'd10 + 7'(w_ones_nxt);
      w_warn_nxt = ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSED)) &&
                   (w_secs_nxt <= WARN_LIM) && (w_secs_nxt != 7'd0);
   end

   // registered warning output
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_warn <= 1'b0;
      end else begin
         r_warn <= w_warn_nxt;
      end
   end

   assign warn = r_warn;
`endif

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed self-checking bench for game_countdown_timer with MS_PER_SEC=4, WARN_SECS=2.
module tb_game_countdown_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ms_tick = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_tens = 4'd0;
   logic [3:0] load_ones = 4'd0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       tick_en;
   logic [3:0] secs_tens;
   logic [3:0] secs_ones;
   logic       running;
   logic       timeout;
`ifdef TIMER_WARN_EN
   logic       warn;
`endif

   int tests  = 0;
   int failed = 0;

   game_countdown_timer #(.MS_PER_SEC(4), .WARN_SECS(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .ms_tick   (ms_tick),
      .load      (load),
      .load_tens (load_tens),
      .load_ones (load_ones),
      .start     (start),
      .pause     (pause),
      .tick_en   (tick_en),
      .secs_tens (secs_tens),
      .secs_ones (secs_ones),
      .running   (running),
`ifdef TIMER_WARN_EN
      .warn      (warn),
`endif
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // checks digits, running, tick_en and timeout in one call
   task automatic expect_out(input string tag, input logic [3:0] t, input logic [3:0] o,
                             input logic run, input logic to);
      chk({tag, ".digits"}, {secs_tens, secs_ones}, {t, o});
      chk({tag, ".running"}, {7'd0, running}, {7'd0, run});
      chk({tag, ".tick_en"}, {7'd0, tick_en}, {7'd0, run});
      chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, to});
   endtask

   task automatic apply(input logic ld, input logic [3:0] lt, input logic [3:0] lo,
                        input logic st, input logic pa, input logic mt);
      load = ld; load_tens = lt; load_ones = lo; start = st; pause = pa; ms_tick = mt;
      @(posedge clk);
      #1;
      load = 1'b0; start = 1'b0; pause = 1'b0; ms_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      expect_out("reset", 4'd0, 4'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // 03 countdown to expiry
      apply(1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
      expect_out("load03", 4'd0, 4'd3, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      expect_out("start03", 4'd0, 4'd3, 1'b1, 1'b0);
      ticks(3);
      expect_out("tick3", 4'd0, 4'd3, 1'b1, 1'b0);
      ticks(1);
      expect_out("tick4", 4'd0, 4'd2, 1'b1, 1'b0);
      ticks(4);
      expect_out("tick8", 4'd0, 4'd1, 1'b1, 1'b0);
      ticks(4);
      expect_out("tick12", 4'd0, 4'd0, 1'b0, 1'b1);
      apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
      expect_out("expired_hold", 4'd0, 4'd0, 1'b0, 1'b0);

      // BCD borrow 10 -> 09
      apply(1'b1, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      ticks(4);
      expect_out("borrow", 4'd0, 4'd9, 1'b1, 1'b0);

      // pause holds partial second
      apply(1'b1, 4'd0, 4'd2, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      ticks(2);
      apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      expect_out("paused", 4'd0, 4'd2, 1'b0, 1'b0);
      ticks(5);
      expect_out("paused_ticks", 4'd0, 4'd2, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      expect_out("resume", 4'd0, 4'd2, 1'b1, 1'b0);
      ticks(1);
      expect_out("resume_t3", 4'd0, 4'd2, 1'b1, 1'b0);
      ticks(1);
      expect_out("resume_t4", 4'd0, 4'd1, 1'b1, 1'b0);

      // start with 00 expires at once
      apply(1'b1, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      expect_out("start00", 4'd0, 4'd0, 1'b0, 1'b1);
      apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
      expect_out("start00_pulse", 4'd0, 4'd0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      expect_out("expired_start", 4'd0, 4'd0, 1'b0, 1'b0);
      apply(1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
      expect_out("reload05", 4'd0, 4'd5, 1'b0, 1'b0);

      // clamp and same-cycle pause/start/tick
      apply(1'b1, 4'hC, 4'hF, 1'b0, 1'b0, 1'b0);
      expect_out("clamp", 4'd9, 4'd9, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b1, 1'b1);
      expect_out("pause_prio", 4'd9, 4'd9, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      ticks(3);
      expect_out("uncounted", 4'd9, 4'd9, 1'b1, 1'b0);
      ticks(1);
      expect_out("counted4", 4'd9, 4'd8, 1'b1, 1'b0);
      apply(1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 1'b1);
      expect_out("load_prio", 4'd4, 4'd4, 1'b0, 1'b0);

      // asynchronous reset mid-run
      apply(1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
      ticks(2);
      #2 rst = 1'b1;
      #1;
      expect_out("async_rst", 4'd0, 4'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      apply(1'b1, 4'd0, 4'd3, 1'b0, 1'b0, 1'b0);
      expect_out("post_rst_load", 4'd0, 4'd3, 1'b0, 1'b0);
      apply(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
`ifdef TIMER_WARN_EN
      chk("warn_03", {7'd0, warn}, 8'd0);
`endif
      ticks(4);
      expect_out("post_rst_tick4", 4'd0, 4'd2, 1'b1, 1'b0);
`ifdef TIMER_WARN_EN
      chk("warn_02", {7'd0, warn}, 8'd1);
      apply(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
      chk("warn_paused", {7'd0, warn}, 8'd1);
      apply(1'b1, 4'd0, 4'd5, 1'b0, 1'b0, 1'b0);
      chk("warn_idle", {7'd0, warn}, 8'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
